// File: rtl/lcd_frame_streamer.sv
// Pixel FIFO plus window/RAM-write command sequencer feeding a 9-bit {DC, byte} SPI writer.
// Optional macro LCD_STREAM_UNDERRUN_FILL_EN: on FIFO underrun, send black fill words instead of stalling.
module lcd_frame_streamer #(
  parameter int H_RES      = 240,
  parameter int V_RES      = 160,
  parameter int X_OFS      = 0,
  parameter int Y_OFS      = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       sys_clk_50MHz,
  input  logic       sys_rst,
  input  logic       start_frame,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       wr_done,
  output logic [8:0] data,
  output logic       en_write,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int TOTAL = H_RES * V_RES;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] XS = 16'(X_OFS);
  localparam logic [15:0] XE = 16'(X_OFS + H_RES - 1);
  localparam logic [15:0] YS = 16'(Y_OFS);
  localparam logic [15:0] YE = 16'(Y_OFS + V_RES - 1);
  localparam logic [PW-1:0] LAST = PW'(TOTAL);

  // state | meaning
  // IDLE  | waiting for start_frame
  // CMD   | sending CASET/RASET/RAMWR words, index in cmd_idx_q
  // PIXEL | sending pixel words, pix_cnt_q = pixels loaded so far
  typedef enum logic [1:0] {IDLE, CMD, PIXEL} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cmd_idx_q, cmd_idx_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [8:0]      data_q, data_d;
  logic            en_q, en_d, busy_q, busy_d, done_q, done_d, urun_q, urun_d;
  logic            pixel_due;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            push, pop, fifo_empty;

  assign pix_ready  = (count_q != (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = pix_valid && pix_ready;

  assign data       = data_q;
  assign en_write   = en_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = urun_q;

  function automatic logic [8:0] cmd_word(input logic [3:0] idx);
    case (idx)
      4'd0:    cmd_word = 9'h02A;
      4'd1:    cmd_word = {1'b1, XS[15:8]};
      4'd2:    cmd_word = {1'b1, XS[7:0]};
      4'd3:    cmd_word = {1'b1, XE[15:8]};
      4'd4:    cmd_word = {1'b1, XE[7:0]};
      4'd5:    cmd_word = 9'h02B;
      4'd6:    cmd_word = {1'b1, YS[15:8]};
      4'd7:    cmd_word = {1'b1, YS[7:0]};
      4'd8:    cmd_word = {1'b1, YE[15:8]};
      4'd9:    cmd_word = {1'b1, YE[7:0]};
      default: cmd_word = 9'h02C;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cmd_idx_d = cmd_idx_q;
    pix_cnt_d = pix_cnt_q;
    data_d    = data_q;
    en_d      = en_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    urun_d    = urun_q;
    pixel_due = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        // frame_done cycle still counts as the tail of the previous frame
        if (start_frame && !done_q) begin
          state_d   = CMD;
          busy_d    = 1'b1;
          urun_d    = 1'b0;
          cmd_idx_d = 4'd0;
          pix_cnt_d = '0;
          data_d    = cmd_word(4'd0);
          en_d      = 1'b1;
        end
      end
      CMD: begin
        if (en_q && wr_done) begin
          if (cmd_idx_q == 4'd10) begin
            state_d   = PIXEL;
            pixel_due = 1'b1;
          end else begin
            cmd_idx_d = cmd_idx_q + 4'd1;
            data_d    = cmd_word(cmd_idx_q + 4'd1);
          end
        end
      end
      PIXEL: begin
        if (en_q && wr_done) begin
          if (pix_cnt_q == LAST) begin
            state_d = IDLE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pixel_due = 1'b1;
          end
        end else if (!en_q) begin
          pixel_due = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pixel_due) begin
      if (!fifo_empty) begin
        data_d    = {1'b1, mem_q[rd_ptr_q]};
        en_d      = 1'b1;
        pop       = 1'b1;
        pix_cnt_d = pix_cnt_q + PW'(1);
      end else begin
`ifdef LCD_STREAM_UNDERRUN_FILL_EN
        data_d    = 9'h100;
        en_d      = 1'b1;
        pix_cnt_d = pix_cnt_q + PW'(1);
`else
        en_d      = 1'b0;
`endif
        urun_d    = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      cmd_idx_q <= '0;
      pix_cnt_q <= '0;
      data_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      urun_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cmd_idx_q <= cmd_idx_d;
      pix_cnt_q <= pix_cnt_d;
      data_q    <= data_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      urun_q    <= urun_d;
      count_q   <= count_d;
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge sys_clk_50MHz) begin
    if (push) mem_q[wr_ptr_q] <= pix_data;
  end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Bench for lcd_frame_streamer: random writer latency and pixel source, frame = command list + pushed bytes.
module tb_lcd_frame_streamer;
  localparam int H = 24, V = 10, XO = 291, YO = 7, TOTAL = H * V, WORDS = 11 + TOTAL;

  logic       clk = 1'b0, rst = 1'b0, start_frame = 1'b0, pix_valid = 1'b0, wr_done = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_ready, en_write, busy, frame_done, underrun;
  logic [8:0] data;

  always #5 clk = ~clk;

  lcd_frame_streamer #(.H_RES(H), .V_RES(V), .X_OFS(XO), .Y_OFS(YO), .FIFO_DEPTH(16)) dut (
    .sys_clk_50MHz(clk), .sys_rst(rst), .start_frame(start_frame),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_done(wr_done), .data(data), .en_write(en_write), .busy(busy),
    .frame_done(frame_done), .underrun(underrun));

  int passed = 0, total = 0;
  logic [8:0] cmd_exp [11];
  logic [8:0] got [$];
  logic [7:0] pushed [$];
  int   fw = 0, hold = 0, wr_lo = 0, wr_hi = 3;
  bit   in_frame = 0, pending = 0, done_due = 0, quiet = 0, start_req = 0, start_on_done = 0;
  logic [8:0] cur = '0;
  logic d_fd, d_busy, d_en;
  bit   d_valid = 0;
  int   done_pulses = 0, busy_err = 0, stable_err = 0, stray_words = 0;
  bit   src_on = 0, src_rand = 0, stray_wr = 0;
  int   src_limit = -1, n_push = 0;
  logic [7:0] src_val = 8'h00;

  // One clock: sample at the negedge, drive the next inputs, advance to the next negedge.
  task automatic tick();
    bit done_now;
    done_now = done_due;
    if (!quiet) begin
      if (done_due) begin
        d_fd = frame_done; d_busy = busy; d_en = en_write; d_valid = 1;
        done_due = 0; in_frame = 0;
        if (start_on_done) begin start_req = 1; start_on_done = 0; end
      end
      if (frame_done === 1'b1) done_pulses++;
      if (in_frame && busy !== 1'b1) busy_err++;
      if (en_write === 1'b1) begin
        if (!pending) begin
          pending = 1; cur = data; hold = $urandom_range(wr_hi, wr_lo);
          if (in_frame) begin got.push_back(data); fw++; end
          else stray_words++;
        end else if (data !== cur) stable_err++;
      end
    end
    wr_done = 1'b0;
    if (pending && !quiet) begin
      if (hold == 0) begin
        wr_done = 1'b1; pending = 0;
        if (in_frame && fw == WORDS) done_due = 1;
      end else hold--;
    end else if (stray_wr && $urandom_range(3, 0) == 0) wr_done = 1'b1;
    pix_valid = 1'b0;
    if (src_on && (src_limit < 0 || n_push < src_limit) && (!src_rand || $urandom_range(3, 0) != 0)) begin
      pix_valid = 1'b1; pix_data = src_val;
    end
    if (pix_valid && pix_ready === 1'b1) begin
      pushed.push_back(pix_data); src_val++; n_push++;
    end
    start_frame = start_req;
    if (start_req && !in_frame && !done_now && !quiet) begin in_frame = 1; fw = 0; end
    start_req = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    pushed.delete(); got.delete();
    in_frame = 0; pending = 0; done_due = 0; fw = 0; d_valid = 0;
  endtask

  task automatic do_reset(input int n);
    src_on = 0; quiet = 1; rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0; quiet = 0;
    clear_model();
  endtask

  task automatic begin_frame();
    d_valid = 0; busy_err = 0; stable_err = 0;
    start_req = 1;
    tick();
  endtask

  task automatic wait_frame(output bit ok);
    int n;
    n = 0;
    while (!d_valid && n < 6000) begin tick(); n++; end
    ok = d_valid;
  endtask

  task automatic wait_words(input int cnt, output bit ok);
    int n;
    n = 0;
    while (!(got.size() >= cnt && !pending) && n < 4000) begin tick(); n++; end
    ok = (got.size() >= cnt);
  endtask

  // Reference frame = 11 command words then the next TOTAL bytes pushed, in push order.
  task automatic score_frame(output int bad, output logic [8:0] g, output logic [8:0] e);
    logic [8:0] ex;
    bad = -1; g = '0; e = '0;
    for (int k = 0; k < WORDS && bad < 0; k++) begin
      ex = (k < 11) ? cmd_exp[k] : ((k - 11 < pushed.size()) ? {1'b1, pushed[k-11]} : 9'h1FF);
      if (k >= got.size() || got[k] !== ex) begin
        bad = k; e = ex; g = (k < got.size()) ? got[k] : 9'h000;
      end
    end
    if (bad < 0 && got.size() != WORDS) begin bad = got.size(); e = '0; g = '0; end
    repeat (TOTAL) if (pushed.size() > 0) void'(pushed.pop_front());
    got.delete();
  endtask

  task automatic test_reset();
    do_reset(2);
    total++; if (en_write !== 1'b0) $display("FAIL reset_en_write got=%b want=0", en_write); else passed++;
    total++; if (data !== 9'h000) $display("FAIL reset_data got=%h want=000", data); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
    total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b want=0", frame_done); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun got=%b want=0", underrun); else passed++;
    total++; if (pix_ready !== 1'b1) $display("FAIL reset_pix_ready got=%b want=1", pix_ready); else passed++;
  endtask

  task automatic test_cmd_sequence();
    bit ok; int bad; logic [8:0] g, e;
    wr_lo = 3; wr_hi = 3; src_on = 1; src_rand = 0; src_limit = -1;
    begin_frame();
    total++; if (busy !== 1'b1) $display("FAIL cmd_busy_after_start got=%b want=1", busy); else passed++;
    wait_frame(ok);
    total++; if (!ok) $display("FAIL cmd_frame_timeout got_words=%0d want=%0d", got.size(), WORDS); else passed++;
    for (int k = 0; k < 11; k++) begin
      total++;
      if (k >= got.size() || got[k] !== cmd_exp[k])
        $display("FAIL cmd_word_%0d got=%h want=%h", k, (k < got.size()) ? got[k] : 9'h000, cmd_exp[k]);
      else passed++;
    end
    score_frame(bad, g, e);
    total++; if (bad >= 0) $display("FAIL cmd_frame_words idx=%0d got=%h want=%h", bad, g, e); else passed++;
    total++; if ({d_fd, d_busy, d_en} !== 3'b100)
      $display("FAIL cmd_frame_done fd/busy/en got=%b%b%b want=100", d_fd, d_busy, d_en); else passed++;
    total++; if (busy_err != 0 || stable_err != 0)
      $display("FAIL cmd_busy_stable busy_err=%0d stable_err=%0d want=0/0", busy_err, stable_err); else passed++;
    // extra wr_done pulses after the frame must not produce words
    stray_wr = 1;
    repeat (30) tick();
    stray_wr = 0;
    total++; if (stray_words != 0 || en_write !== 1'b0)
      $display("FAIL extra_wr_done words=%0d en_write=%b want=0/0", stray_words, en_write); else passed++;
    total++; if (done_pulses != 1) $display("FAIL done_pulse_count got=%0d want=1", done_pulses); else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok; int bad; logic [8:0] g, e;
    wr_lo = 0; wr_hi = 3; src_on = 1; src_rand = 1; src_limit = -1;
    begin_frame();
    start_on_done = 1;
    wait_frame(ok);
    score_frame(bad, g, e);
    total++; if (!ok || bad >= 0) $display("FAIL b2b_frame1 idx=%0d got=%h want=%h", bad, g, e); else passed++;
    // start_frame coincided with frame_done above and must have been ignored
    total++; if (en_write !== 1'b0 || busy !== 1'b0)
      $display("FAIL start_on_done_ignored en=%b busy=%b want=0/0", en_write, busy); else passed++;
    begin_frame();
    total++; if (underrun !== 1'b0) $display("FAIL b2b_underrun_cleared got=%b want=0", underrun); else passed++;
    wait_frame(ok);
    score_frame(bad, g, e);
    total++; if (!ok || bad >= 0) $display("FAIL b2b_frame2 idx=%0d got=%h want=%h", bad, g, e); else passed++;
    total++; if ({d_fd, d_busy, d_en} !== 3'b100 || busy_err != 0 || stable_err != 0)
      $display("FAIL b2b_done fd/busy/en=%b%b%b busy_err=%0d stable_err=%0d", d_fd, d_busy, d_en, busy_err, stable_err);
    else passed++;
  endtask

  task automatic test_fifo_full();
    bit ok; int bad; logic [8:0] g, e;
    do_reset(1);
    src_on = 1; src_rand = 0; src_limit = n_push + 17;
    repeat (15) tick();
    total++; if (pix_ready !== 1'b1) $display("FAIL fifo_ready_at_15 got=%b want=1", pix_ready); else passed++;
    tick();
    total++; if (pix_ready !== 1'b0) $display("FAIL fifo_ready_at_16 got=%b want=0", pix_ready); else passed++;
    repeat (5) tick();
    total++; if (pix_ready !== 1'b0 || pushed.size() != 16)
      $display("FAIL fifo_full_hold ready=%b accepted=%0d want=0/16", pix_ready, pushed.size()); else passed++;
    wr_lo = 0; wr_hi = 3;
    begin_frame();
    src_limit = -1;
    wait_frame(ok);
    score_frame(bad, g, e);
    total++; if (!ok || bad >= 0) $display("FAIL fifo_full_frame idx=%0d got=%h want=%h", bad, g, e); else passed++;
  endtask

  task automatic test_abort();
    bit ok, pre_ok; int pulses; logic [8:0] ex;
    wr_lo = 0; wr_hi = 2; src_on = 1; src_rand = 0; src_limit = -1;
    begin_frame();
    wait_words(11 + 50, ok);
    start_req = 1;
    tick();
    wait_words(11 + 100, ok);
    pre_ok = ok;
    for (int k = 0; k < got.size(); k++) begin
      ex = (k < 11) ? cmd_exp[k] : ((k - 11 < pushed.size()) ? {1'b1, pushed[k-11]} : 9'h1FF);
      if (got[k] !== ex) pre_ok = 0;
    end
    total++; if (!pre_ok) $display("FAIL abort_midframe_start got_words=%0d stream_ok=%b want=1", got.size(), pre_ok); else passed++;
    pulses = done_pulses;
    src_on = 0; quiet = 1; rst = 1'b1;
    tick();
    rst = 1'b0; quiet = 0;
    clear_model();
    total++; if (en_write !== 1'b0) $display("FAIL abort_en_write got=%b want=0", en_write); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b want=0", busy); else passed++;
    total++; if (pix_ready !== 1'b1) $display("FAIL abort_fifo_empty pix_ready=%b want=1", pix_ready); else passed++;
    stray_words = 0;
    repeat (20) tick();
    total++; if (done_pulses != pulses || stray_words != 0 || frame_done !== 1'b0)
      $display("FAIL abort_quiet done_pulses=%0d words=%0d want=%0d/0", done_pulses, stray_words, pulses); else passed++;
    src_on = 1;
    begin_frame();
    total++; if (en_write !== 1'b1 || data !== 9'h02A)
      $display("FAIL abort_restart en=%b data=%h want=1/02a", en_write, data); else passed++;
    wait_frame(ok);
    got.delete();
    repeat (TOTAL) if (pushed.size() > 0) void'(pushed.pop_front());
    total++; if (!ok) $display("FAIL abort_restart_timeout got=0 want=frame_done"); else passed++;
  endtask

  task automatic test_underrun();
    bit ok; int bad, gap_bad, base; logic [8:0] g, e;
    wr_lo = 0; wr_hi = 3; src_on = 1; src_rand = 0;
    base = n_push - pushed.size();
    src_limit = base + 100;
    begin_frame();
    wait_words(11 + 100, ok);
    gap_bad = 0;
    for (int c = 0; c < 50; c++) begin
`ifdef LCD_STREAM_UNDERRUN_FILL_EN
      if (underrun !== 1'b1 || en_write !== 1'b1) gap_bad++;
`else
      if (underrun !== 1'b1 || en_write !== 1'b0) gap_bad++;
`endif
      tick();
    end
    total++; if (!ok || gap_bad != 0) $display("FAIL underrun_gap bad_cycles=%0d want=0", gap_bad); else passed++;
    src_limit = -1;
    wait_frame(ok);
`ifdef LCD_STREAM_UNDERRUN_FILL_EN
    total++; if (!ok || got.size() != WORDS) $display("FAIL underrun_fill_total got=%0d want=%0d", got.size(), WORDS); else passed++;
    got.delete();
`else
    score_frame(bad, g, e);
    total++; if (!ok || bad >= 0) $display("FAIL underrun_frame idx=%0d got=%h want=%h", bad, g, e); else passed++;
`endif
    total++; if (underrun !== 1'b1) $display("FAIL underrun_sticky got=%b want=1", underrun); else passed++;
  endtask

  initial begin
    cmd_exp[0]  = 9'h02A;
    cmd_exp[1]  = {1'b1, 8'(XO >> 8)};
    cmd_exp[2]  = {1'b1, 8'(XO)};
    cmd_exp[3]  = {1'b1, 8'((XO + H - 1) >> 8)};
    cmd_exp[4]  = {1'b1, 8'(XO + H - 1)};
    cmd_exp[5]  = 9'h02B;
    cmd_exp[6]  = {1'b1, 8'(YO >> 8)};
    cmd_exp[7]  = {1'b1, 8'(YO)};
    cmd_exp[8]  = {1'b1, 8'((YO + V - 1) >> 8)};
    cmd_exp[9]  = {1'b1, 8'(YO + V - 1)};
    cmd_exp[10] = 9'h02C;
    test_reset();
    test_cmd_sequence();
    test_back_to_back();
    test_fifo_full();
    test_abort();
    test_underrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
